// File: rtl/spi_peripheral_word.sv
// spi_peripheral_word
//   SPI peripheral (target) with a configurable word width, any of the four
//   SPI modes, and back-to-back words inside one chip-select window. Words are
//   sent and received MSB first.
//
//   A one-entry transmit holding register (tx_data/tx_valid/tx_ready) feeds
//   the shifter. Each received word appears on rx_data with a one-cycle
//   rx_valid strobe. There is no backpressure on the receive side.
//
//   Parameters:
//     WIDTH        bits per word (>= 4)
//     CPOL         SCK idle level
//     CPHA         0: sample on leading edge, shift on trailing edge
//                  1: shift on leading edge, sample on trailing edge
//     SYNC_STAGES  synchroniser depth on sck/cs_n/copi (>= 2)
//
//   Ports:
//     clk, rst     system clock, asynchronous active-high reset
//     sck, cs_n    SPI clock and active-low chip select from the controller
//     copi         controller-out data
//     cipo         peripheral-out data, 0 while not selected
//     cipo_oe      enable for the top-level tristate (synced CS active)
//     tx_data      next word to send, accepted when tx_valid && tx_ready
//     tx_valid     tx_data valid
//     tx_ready     holding register empty
//     rx_data      last complete received word
//     rx_valid     one-cycle strobe, rx_data updated
//     tx_underrun  one-cycle strobe, a word started with the holding register empty
//
//   Optional build macro SPI_ABORT_FLAG_EN adds:
//     rx_abort     one-cycle strobe when CS drops in the middle of a word
//     abort_cnt    number of aborts seen since reset, saturating at 255
//
//   Supported SCK rate is clk/8 or slower.
module spi_peripheral_word #(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             copi,
  output logic             cipo,
  output logic             cipo_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun
`ifdef SPI_ABORT_FLAG_EN
  ,
  output logic             rx_abort,
  output logic [7:0]       abort_cnt
`endif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] sck_p0, cs_n_p0, copi_p0, flush_p0;
  logic                   sck_s, cs_n_s, copi_s;

  logic                   sck_p1, cs_act_p1;
  logic                   armed;
  logic                   cs_act, cs_start;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   load;

  logic [CW-1:0]          bit_cnt;
  logic                   word_end;
  logic                   und_pend;
  logic                   hold_full;
  logic [WIDTH-1:0]       hold_data;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-2:0]       rx_shift;

  // ---- stage p0: pin synchronisers ----
  // flush_p0 fills with ones after reset; once its last bit is set the
  // synchroniser contents come from the real pins rather than reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_p0   <= {SYNC_STAGES{CPOL}};
      cs_n_p0  <= '1;
      copi_p0  <= '0;
      flush_p0 <= '0;
    end else begin
      sck_p0   <= {sck_p0[SYNC_STAGES-2:0], sck};
      cs_n_p0  <= {cs_n_p0[SYNC_STAGES-2:0], cs_n};
      copi_p0  <= {copi_p0[SYNC_STAGES-2:0], copi};
      flush_p0 <= {flush_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sck_s  = sck_p0[SYNC_STAGES-1];
  assign cs_n_s = cs_n_p0[SYNC_STAGES-1];
  assign copi_s = copi_p0[SYNC_STAGES-1];

  // After a reset the block stays deaf until CS has been seen inactive,
  // so a reset in the middle of a window cannot restart a half-sent word.
  assign cs_act   = armed & ~cs_n_s;
  assign cs_start = cs_act & ~cs_act_p1;

  // ---- stage p1: edge detection against the registered synced SCK ----
  assign lead_edge   = (sck_p1 == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_p1 != CPOL) && (sck_s == CPOL);
  assign sample_edge = cs_act && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = cs_act && (CPHA ? lead_edge : trail_edge);

  // CPHA=0 needs the first bit on the wire before any SCK edge, so the first
  // word loads at CS assertion and each following word loads on the shift
  // edge that closes the previous word. CPHA=1 loads on the leading edge of
  // every word.
  always_comb begin
    load = 1'b0;
    if (CPHA) load = shift_edge && (bit_cnt == '0);
    else      load = cs_start || (shift_edge && word_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_p1      <= CPOL;
      cs_act_p1   <= 1'b0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      word_end    <= 1'b0;
      und_pend    <= 1'b0;
      hold_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_p1      <= sck_s;
      cs_act_p1   <= cs_act;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (flush_p0[SYNC_STAGES-1] && cs_n_s) armed <= 1'b1;

      if (!cs_act) begin
        bit_cnt  <= '0;
        word_end <= 1'b0;
        und_pend <= 1'b0;
      end else begin
        if (sample_edge) begin
          if (bit_cnt == LAST) begin
            bit_cnt  <= '0;
            rx_data  <= {rx_shift, copi_s};
            rx_valid <= 1'b1;
            word_end <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (und_pend) begin
            tx_underrun <= 1'b1;
            und_pend    <= 1'b0;
          end
        end
        // With CPHA=0 the closing reload also happens after the final word
        // of a window, so an empty load is reported only once the word
        // actually starts (its first sample); a CS release cancels it.
        if (load) begin
          word_end <= 1'b0;
          if (!hold_full) begin
            if (CPHA) tx_underrun <= 1'b1;
            else      und_pend    <= 1'b1;
          end
        end
      end

      if (load && hold_full)            hold_full <= 1'b0;
      else if (tx_valid && !hold_full)  hold_full <= 1'b1;
    end
  end

  // ---- stage p1: data shifters and holding register (no reset needed) ----
  always_ff @(posedge clk) begin
    if (!cs_act)         tx_shift <= '0;
    else if (load)       tx_shift <= hold_full ? hold_data : '0;
    else if (shift_edge) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};

    if (sample_edge) rx_shift <= {rx_shift[WIDTH-3:0], copi_s};

    if (tx_valid && !hold_full) hold_data <= tx_data;
  end

  assign tx_ready = ~hold_full;
  assign cipo_oe  = cs_act;
  assign cipo     = cs_act & tx_shift[WIDTH-1];

`ifdef SPI_ABORT_FLAG_EN
  logic cs_end, abort_now;
  assign cs_end    = ~cs_act & cs_act_p1;
  assign abort_now = cs_end && (bit_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_abort  <= 1'b0;
      abort_cnt <= '0;
    end else begin
      rx_abort <= abort_now;
      if (abort_now && (abort_cnt != 8'hFF)) abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_peripheral_word.sv
// Testbench for spi_peripheral_word. Two instances are exercised:
//   dut0: WIDTH=8,  CPOL=0, CPHA=0
//   dut1: WIDTH=16, CPOL=1, CPHA=1
// A controller task drives SCK/CS/COPI and collects CIPO. Expected received
// words, underrun strobes and abort strobes are queued before each window
// and consumed by monitor processes when the DUT strobes them.
`timescale 1ns/1ps
module tb_spi_peripheral_word;

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sck0, cs_n0, copi0, cipo0, oe0, txv0, txr0, rxv0, und0;
  logic [7:0] txd0, rxd0;
  logic        sck1, cs_n1, copi1, cipo1, oe1, txv1, txr1, rxv1, und1;
  logic [15:0] txd1, rxd1;
`ifdef SPI_ABORT_FLAG_EN
  logic       abt0, abt1;
  logic [7:0] acnt0, acnt1;
`endif

  spi_peripheral_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .sck(sck0), .cs_n(cs_n0), .copi(copi0),
    .cipo(cipo0), .cipo_oe(oe0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0), .tx_underrun(und0)
`ifdef SPI_ABORT_FLAG_EN
    , .rx_abort(abt0), .abort_cnt(acnt0)
`endif
  );

  spi_peripheral_word #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sck(sck1), .cs_n(cs_n1), .copi(copi1),
    .cipo(cipo1), .cipo_oe(oe1), .tx_data(txd1), .tx_valid(txv1),
    .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1), .tx_underrun(und1)
`ifdef SPI_ABORT_FLAG_EN
    , .rx_abort(abt1), .abort_cnt(acnt1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model state: words written to the holding register, in order
  logic [15:0] tx_q0[$], tx_q1[$];
  // scoreboard queues
  logic [15:0] rx_q0[$], rx_q1[$];
  int          und_q0[$], und_q1[$], abt_q0[$], abt_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int width(input int d);
    return (d == 0) ? 8 : 16;
  endfunction
  function automatic logic pol(input int d);
    return (d == 1);
  endfunction
  function automatic logic pha(input int d);
    return (d == 1);
  endfunction

  task automatic set_sck(input int d, input logic v);
    if (d == 0) sck0 = v; else sck1 = v;
  endtask
  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs_n0 = v; else cs_n1 = v;
  endtask
  task automatic set_copi(input int d, input logic v);
    if (d == 0) copi0 = v; else copi1 = v;
  endtask
  task automatic set_tx(input int d, input logic v, input logic [15:0] data);
    if (d == 0) begin txv0 = v; txd0 = data[7:0]; end
    else        begin txv1 = v; txd1 = data; end
  endtask
  function automatic logic get_cipo(input int d);
    return (d == 0) ? cipo0 : cipo1;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? txr0 : txr1;
  endfunction
  function automatic int txq_size(input int d);
    return (d == 0) ? tx_q0.size() : tx_q1.size();
  endfunction

  // Write one word into the holding register once tx_ready is seen.
  task automatic write_tx(input int d, input logic [15:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!get_ready(d) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL write_tx_timeout: dut%0d tx_ready stayed %b, required 1", d, get_ready(d));
    end else begin
      set_tx(d, 1'b1, v);
      @(negedge clk);
      set_tx(d, 1'b0, 16'h0);
    end
  endtask

  // Controller: one CS window of nbits bits, MSB of the nbits-wide field first.
  task automatic xfer(input int d, input int nbits, input logic [31:0] mosi,
                      input bit end_cs, output logic [31:0] miso);
    logic p;
    p = pol(d);
    miso = '0;
    set_sck(d, p);
    if (!pha(d)) set_copi(d, mosi[nbits-1]);
    set_cs(d, 1'b0);
    #(2*HALF);
    for (int i = 0; i < nbits; i++) begin
      if (!pha(d)) begin
        #HALF; miso = {miso[30:0], get_cipo(d)}; set_sck(d, ~p);
        #HALF; set_sck(d, p);
        if (i + 1 < nbits) set_copi(d, mosi[nbits-2-i]);
      end else begin
        #HALF; set_sck(d, ~p); set_copi(d, mosi[nbits-1-i]);
        #HALF; miso = {miso[30:0], get_cipo(d)}; set_sck(d, p);
      end
    end
    #HALF;
    if (end_cs) set_cs(d, 1'b1);
    #HALF;
  endtask

  // Reference model of one window: every word that starts takes the oldest
  // written word (or zeros plus an underrun if none is waiting). In CPHA=0
  // the holding register is also drained once after the last complete word.
  task automatic model_window(input int d, input int nw, input int part,
                              input logic [31:0] mosi, output logic [31:0] exp_miso);
    int          w, loads, starts;
    logic [31:0] mask;
    logic [15:0] v;
    bit          empty;
    w      = width(d);
    mask   = (32'h1 << w) - 32'h1;
    starts = nw + ((part > 0) ? 1 : 0);
    loads  = pha(d) ? starts : nw + 1;
    exp_miso = '0;
    for (int i = 0; i < loads; i++) begin
      empty = (txq_size(d) == 0);
      v = 16'h0;
      if (!empty) begin
        if (d == 0) v = tx_q0.pop_front(); else v = tx_q1.pop_front();
      end
      if (i < nw)          exp_miso = (exp_miso << w) | 32'(v);
      else if (i < starts) exp_miso = (exp_miso << part) | (32'(v) >> (w - part));
      if (empty && i < starts) begin
        if (d == 0) und_q0.push_back(1); else und_q1.push_back(1);
      end
    end
    for (int k = 0; k < nw; k++) begin
      v = 16'((mosi >> ((nw - 1 - k) * w + part)) & mask);
      if (d == 0) rx_q0.push_back(v); else rx_q1.push_back(v);
    end
`ifdef SPI_ABORT_FLAG_EN
    if (part > 0) begin
      if (d == 0) abt_q0.push_back(1); else abt_q1.push_back(1);
    end
`endif
  endtask

  task automatic drain(input int d, input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_rx_missing"},  32'((d == 0) ? rx_q0.size()  : rx_q1.size()),  32'd0);
    chk({tag, "_und_missing"}, 32'((d == 0) ? und_q0.size() : und_q1.size()), 32'd0);
`ifdef SPI_ABORT_FLAG_EN
    chk({tag, "_abort_missing"}, 32'((d == 0) ? abt_q0.size() : abt_q1.size()), 32'd0);
`endif
  endtask

  // One full window: nwr words written (first before CS, rest while running).
  task automatic window(input int d, input int nw, input int part, input logic [31:0] mosi,
                        input int nwr, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input string tag);
    logic [15:0] wv[3];
    logic [31:0] exp_miso, miso;
    wv[0] = w0; wv[1] = w1; wv[2] = w2;
    for (int j = 0; j < nwr; j++) begin
      if (d == 0) tx_q0.push_back(16'(wv[j] & 16'h00FF)); else tx_q1.push_back(wv[j]);
    end
    model_window(d, nw, part, mosi, exp_miso);
    if (nwr >= 1) write_tx(d, wv[0]);
    fork
      xfer(d, nw * width(d) + part, mosi, 1'b1, miso);
      begin
        for (int j = 1; j < nwr; j++) write_tx(d, wv[j]);
      end
    join
    chk({tag, "_cipo_word"}, miso, exp_miso);
    drain(d, tag);
    chk({tag, "_tx_ready"}, 32'(get_ready(d)), 32'(txq_size(d) == 0));
  endtask

  // ---- monitors ----
  always @(negedge clk) begin
    if (!rst) begin
      if (rxv0) begin
        chk("rx0_expected", 32'(rx_q0.size() > 0), 32'd1);
        if (rx_q0.size() > 0) chk("rx0_data", 32'(rxd0), 32'(rx_q0.pop_front()));
      end
      if (rxv1) begin
        chk("rx1_expected", 32'(rx_q1.size() > 0), 32'd1);
        if (rx_q1.size() > 0) chk("rx1_data", 32'(rxd1), 32'(rx_q1.pop_front()));
      end
      if (und0) begin
        chk("und0_expected", 32'(und_q0.size() > 0), 32'd1);
        if (und_q0.size() > 0) void'(und_q0.pop_front());
      end
      if (und1) begin
        chk("und1_expected", 32'(und_q1.size() > 0), 32'd1);
        if (und_q1.size() > 0) void'(und_q1.pop_front());
      end
`ifdef SPI_ABORT_FLAG_EN
      if (abt0) begin
        chk("abort0_expected", 32'(abt_q0.size() > 0), 32'd1);
        if (abt_q0.size() > 0) void'(abt_q0.pop_front());
      end
      if (abt1) begin
        chk("abort1_expected", 32'(abt_q1.size() > 0), 32'd1);
        if (abt_q1.size() > 0) void'(abt_q1.pop_front());
      end
`endif
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] miso, mosi, mask;
    int          d, nw, nwr, nb;
    sck0 = 1'b0; cs_n0 = 1'b1; copi0 = 1'b0; txv0 = 1'b0; txd0 = '0;
    sck1 = 1'b1; cs_n1 = 1'b1; copi1 = 1'b0; txv1 = 1'b0; txd1 = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // reset state
    chk("rst0_cipo",     32'(cipo0), 32'd0);
    chk("rst0_cipo_oe",  32'(oe0),   32'd0);
    chk("rst0_rx_data",  32'(rxd0),  32'd0);
    chk("rst0_rx_valid", 32'(rxv0),  32'd0);
    chk("rst0_underrun", 32'(und0),  32'd0);
    chk("rst0_tx_ready", 32'(txr0),  32'd1);
    chk("rst1_cipo",     32'(cipo1), 32'd0);
    chk("rst1_cipo_oe",  32'(oe1),   32'd0);
    chk("rst1_rx_data",  32'(rxd1),  32'd0);
    chk("rst1_tx_ready", 32'(txr1),  32'd1);

    // directed cases
    window(0, 1, 0, 32'h3C,      1, 16'hA5,   16'h0,  16'h0, "m0_basic");
    window(1, 1, 0, 32'h1234,    1, 16'hBEEF, 16'h0,  16'h0, "m3_w16");
    window(0, 2, 0, 32'h6699,    2, 16'h11,   16'h22, 16'h0, "m0_b2b");
    window(0, 1, 0, 32'h81,      0, 16'h0,    16'h0,  16'h0, "m0_underrun");
    window(0, 0, 5, 32'h16,      0, 16'h0,    16'h0,  16'h0, "m0_partial");
    chk("partial_rx_data_held", 32'(rxd0), 32'h81);
`ifdef SPI_ABORT_FLAG_EN
    chk("partial_abort_cnt", 32'(acnt0), 32'd1);
`endif
    window(0, 1, 0, 32'hC3,      1, 16'h3C,   16'h0,  16'h0, "m0_after_partial");
    window(1, 2, 0, 32'hCAFEF00D, 1, 16'h8001, 16'h0, 16'h0, "m3_b2b_underrun");

    // asynchronous reset in the middle of a word
    tx_q0.push_back(16'h77);
    write_tx(0, 16'h77);
    xfer(0, 3, 32'h5, 1'b0, miso);
    chk("pre_rst_cipo_oe", 32'(oe0), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cipo",     32'(cipo0), 32'd0);
    chk("arst_cipo_oe",  32'(oe0),   32'd0);
    chk("arst_rx_data",  32'(rxd0),  32'd0);
    chk("arst_rx_valid", 32'(rxv0),  32'd0);
    chk("arst_underrun", 32'(und0),  32'd0);
    chk("arst_tx_ready", 32'(txr0),  32'd1);
    chk("arst1_rx_data", 32'(rxd1),  32'd0);
`ifdef SPI_ABORT_FLAG_EN
    chk("arst_abort_cnt", 32'(acnt0), 32'd0);
`endif
    tx_q0.delete();
    tx_q1.delete();
    set_cs(0, 1'b1);
    set_sck(0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    window(0, 1, 0, 32'h5A, 1, 16'h96, 16'h0, 16'h0, "post_rst");

    // randomized windows on both instances
    for (int r = 0; r < 12; r++) begin
      d   = r % 2;
      nw  = (d == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 2));
      nwr = int'($urandom_range(0, nw));
      nb  = nw * width(d);
      mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
      mosi = $urandom & mask;
      window(d, nw, 0, mosi, nwr, 16'($urandom), 16'($urandom), 16'($urandom),
             (d == 0) ? "rand_m0" : "rand_m3");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
